// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serialises a mono sample stream onto both channels of a Philips I2S frame
module i2s_transmitter #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int MCLK_DIV   = 4
) (
  input  logic                  clk_pll_12_28_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  bclk_o,
  output logic                  lrclk_o,
  output logic                  sdata_o,
  output logic                  frame_start_o,
  output logic                  underrun_o
);
  localparam int DIV_W      = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;

  logic                  div_wrap;
  logic                  load;
  logic                  accept;
  logic                  slot;
  logic [BIT_W-1:0]      b;
  logic                  data_bit;

  // Next-state: counters, one-entry buffer, frame register and registered pin values
  always_comb begin
    div_wrap      = div_cnt_q == DIV_LAST;
    load          = div_wrap && (bit_cnt_q == BIT_LAST);
    slot          = bit_cnt_q >= SLOT_LEN;
    b             = slot ? bit_cnt_q - SLOT_LEN : bit_cnt_q;
    accept        = valid_i && !pend_v_q;
    data_bit      = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (b == BIT_W'(DATA_WIDTH - i)) data_bit = frame_q[i];
    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d     = !div_wrap ? bit_cnt_q : (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    pend_d        = accept ? sample_i : pend_q;
    pend_v_d      = accept || (pend_v_q && !load);
    frame_d       = (load && pend_v_q) ? pend_q : frame_q;
    bclk_d        = div_cnt_q >= DIV_HALF;
    lrclk_d       = slot;
    sdata_d       = data_bit;
    frame_start_d = load;
    underrun_d    = load && !pend_v_q;
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk_pll_12_28_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      pend_q        <= '0;
      pend_v_q      <= 1'b0;
      frame_q       <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      frame_q       <= frame_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign ready_o       = !pend_v_q;
  assign bclk_o        = bclk_q;
  assign lrclk_o       = lrclk_q;
  assign sdata_o       = sdata_q;
  assign frame_start_o = frame_start_q;
  assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: directed scenarios plus random traffic against a cycle-position reference model
module tb_i2s_transmitter;
  localparam int DW = 24;
  localparam int SW = 32;
  localparam int MD = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] sample_i = '0;
  logic          ready_o, bclk_o, lrclk_o, sdata_o, frame_start_o, underrun_o;
  int            n_chk = 0;
  int            n_err = 0;

  i2s_transmitter #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .MCLK_DIV(MD)) dut (
    .clk_pll_12_28_i(clk),
    .rst_ni(rst_ni),
    .sample_i(sample_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .bclk_o(bclk_o),
    .lrclk_o(lrclk_o),
    .sdata_o(sdata_o),
    .frame_start_o(frame_start_o),
    .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame is plain arithmetic on cycles since reset
  int            m_s;
  int            m_div, m_bi, m_b;
  logic          m_l, m_rdy;
  logic [DW-1:0] m_frame;
  logic [DW-1:0] m_q[$];
  logic          e_bclk = 0, e_lr = 0, e_sd = 0, e_fs = 0, e_ur = 0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_s = 0;
      m_q.delete();
      m_frame = '0;
      e_bclk = 0; e_lr = 0; e_sd = 0; e_fs = 0; e_ur = 0;
    end
    chk("bclk", bclk_o, e_bclk);
    chk("lrclk", lrclk_o, e_lr);
    chk("sdata", sdata_o, e_sd);
    chk("frame_start", frame_start_o, e_fs);
    chk("underrun", underrun_o, e_ur);
    chk("ready", ready_o, m_q.size() == 0);
    if (rst_ni) begin
      m_div  = m_s % MD;
      m_bi   = (m_s / MD) % (2 * SW);
      m_b    = m_bi % SW;
      m_l    = (m_div == MD - 1) && (m_bi == 2 * SW - 1);
      m_rdy  = m_q.size() == 0;
      e_bclk = m_div >= MD / 2;
      e_lr   = m_bi >= SW;
      e_sd   = (m_b >= 1 && m_b <= DW) ? m_frame[DW - m_b] : 1'b0;
      e_fs   = m_l;
      e_ur   = m_l && m_rdy;
      if (m_l && !m_rdy) m_frame = m_q.pop_front();
      if (valid_i && m_rdy) m_q.push_back(sample_i);
      m_s++;
    end
  end

  task automatic wait_fs(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_start_o) return;
    end
    chk({name, "_timeout"}, frame_start_o, 1'b1);
  endtask

  task automatic count_to_fs(output int n);
    n = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_start_o) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic capture(output logic [63:0] bits);
    logic prev;
    int   n;
    prev = 1'b1;
    n    = 0;
    bits = '0;
    for (int i = 0; i < 300 && n < 64; i++) begin
      @(negedge clk);
      if (bclk_o && !prev) begin
        bits = {bits[62:0], sdata_o};
        n++;
      end
      prev = bclk_o;
    end
  endtask

  task automatic send(input logic [DW-1:0] x, output logic fs_at_accept);
    @(posedge clk);
    #1 sample_i = x;
    valid_i = 1'b1;
    fs_at_accept = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ready_o) break;
    end
    chk("send_accept", ready_o, 1'b1);
    fs_at_accept = frame_start_o;
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  int          n;
  int          u_cnt;
  logic        f;
  logic [63:0] bits;

  initial begin
    repeat (10) @(posedge clk);
    #1 rst_ni = 1'b1;
    count_to_fs(n);
    chk("first_fs_cycle", n, 256);
    chk("first_fs_underrun", underrun_o, 1'b1);

    send(24'hA5F00F, f);
    chk("ready_after_xfer", ready_o, 1'b0);
    wait_fs("single");
    chk("single_no_underrun", underrun_o, 1'b0);
    chk("single_ready_back", ready_o, 1'b1);
    capture(bits);
    chk("single_frame", bits, 64'h52F8078052F80780);

    send(24'h000001, f);
    send(24'h800000, f);
    chk("bp_release_on_fs", f, 1'b1);
    capture(bits);
    chk("bp_frame1", bits, 64'h0000008000000080);
    wait_fs("bp");
    capture(bits);
    chk("bp_frame2", bits, 64'h4000000040000000);

    send(24'h123456, f);
    wait_fs("ur_load");
    chk("ur_load_no_underrun", underrun_o, 1'b0);
    capture(bits);
    chk("ur_frame0", bits, 64'h091A2B00091A2B00);
    u_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      wait_fs("ur");
      u_cnt += int'(underrun_o);
      capture(bits);
      chk("ur_repeat", bits, 64'h091A2B00091A2B00);
    end
    chk("ur_count", u_cnt, 3);

    wait_fs("coll");
    repeat (254) @(negedge clk);
    @(posedge clk);
    #1 sample_i = 24'h7FFFFF;
    valid_i = 1'b1;
    @(negedge clk);
    chk("coll_ready_in_L", ready_o, 1'b1);
    @(posedge clk);
    #1 valid_i = 1'b0;
    chk("coll_fs", frame_start_o, 1'b1);
    chk("coll_underrun", underrun_o, 1'b1);
    chk("coll_ready_low", ready_o, 1'b0);
    capture(bits);
    chk("coll_old_frame", bits, 64'h091A2B00091A2B00);
    wait_fs("coll_next");
    chk("coll_next_no_underrun", underrun_o, 1'b0);
    capture(bits);
    chk("coll_new_frame", bits, 64'h3FFFFF803FFFFF80);

    send(24'h5A5A5A, f);
    repeat (160) @(negedge clk);
    chk("pre_reset_bclk", bclk_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1 chk("rst_bclk", bclk_o, 1'b0);
    chk("rst_lrclk", lrclk_o, 1'b0);
    chk("rst_sdata", sdata_o, 1'b0);
    chk("rst_fs", frame_start_o, 1'b0);
    chk("rst_underrun", underrun_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst_ni = 1'b1;
    count_to_fs(n);
    chk("rerun_fs_cycle", n, 256);
    chk("rerun_underrun", underrun_o, 1'b1);
    capture(bits);
    chk("rerun_zero_frame", bits, 64'h0);

    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1 valid_i = $urandom_range(0, 99) < ((i < 2500) ? 3 : 30);
      sample_i = DW'($urandom);
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (300) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises the synthesised mono audio stream into a standard Philips I2S frame for the board's audio DAC. It sits directly downstream of the envelope/amplitude-modulation stage and consumes its `DATA_WIDTH` sample output through a valid/ready handshake with a one-entry holding buffer. It generates BCLK, LRCLK and SDATA from the 12.288 MHz PLL clock and drives the same sample onto both channels. At defaults it runs at 64·fs, giving fs = 48 kHz.

## Interface
- `DATA_WIDTH`, 24: sample width, two's complement; must be ≤ `SLOT_WIDTH`-1.
- `SLOT_WIDTH`, 32: BCLK periods per channel slot.
- `MCLK_DIV`, 4: system clocks per BCLK period; even, ≥2.
- `clk_pll_12_28_i`  in  1  system/audio clock, 12.288 MHz.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `sample_i`  in  `DATA_WIDTH`  sample from upstream modulator.
- `valid_i`  in  1  `sample_i` valid.
- `ready_o`  out  1  holding buffer empty; transfer when `valid_i && ready_o`.
- `bclk_o`  out  1  I2S bit clock.
- `lrclk_o`  out  1  word select: 0 = left, 1 = right.
- `sdata_o`  out  1  I2S serial data, MSB first.
- `frame_start_o`  out  1  one-cycle pulse on frame-register load.
- `underrun_o`  out  1  one-cycle pulse when a load finds the buffer empty.

## Operation
- `div_cnt`: counts 0..`MCLK_DIV`-1, wraps.
- `bit_cnt`: counts 0..2·`SLOT_WIDTH`-1; increments when `div_cnt` wraps, and itself wraps.
- `slot`: `bit_cnt[log2 SLOT_WIDTH]`.
- `b`: `bit_cnt mod SLOT_WIDTH`.
- Buffer: `pend` register and `pend_v` flag.
  - `ready_o = !pend_v`.
  - On transfer, `pend <= sample_i` and `pend_v <= 1`.
- Load cycle (L): `div_cnt == MCLK_DIV-1` and `bit_cnt == 2·SLOT_WIDTH-1`.
  - If `pend_v`: `frame <= pend`, `pend_v <= 0`, `frame_start_o` = 1.
  - If not `pend_v`: `frame` is held (last sample repeats), `frame_start_o` = 1, `underrun_o` = 1.
  - If `valid_i` arrives in L while the buffer is empty: the sample is accepted into `pend`, is not used for this frame, and the underrun is still flagged.
  - A `valid_i` in L while `pend_v` = 1 is not accepted, because `ready_o` = 0.
- Serial data per slot (both slots carry `frame`):
  - `b` = 0: 0 (one-BCLK I2S delay after the LRCLK edge).
  - `b` = 1..`DATA_WIDTH`: `frame[DATA_WIDTH-b]`.
  - Otherwise: 0.
- Derived outputs: `bclk_o` = (`div_cnt` ≥ `MCLK_DIV`/2), `lrclk_o` = `slot`.
  - `lrclk_o` and `sdata_o` therefore change only while BCLK is low, i.e. at the BCLK falling edge.
  - The DAC samples on the BCLK rising edge.

## Timing
- Reset (`rst_ni` = 0, asynchronous):
  - `div_cnt`, `bit_cnt`, `frame`, `pend` and `pend_v` clear.
  - `bclk_o`, `lrclk_o`, `sdata_o`, `frame_start_o` and `underrun_o` = 0.
  - `ready_o` = 1.
- A reset asserted mid-frame aborts the frame immediately. The first cycle after release has `div_cnt` = `bit_cnt` = 0.
- `bclk_o`, `lrclk_o`, `sdata_o`, `frame_start_o` and `underrun_o` are registered: each reflects counter/`frame` state one clock earlier.
- `ready_o` is combinational from `pend_v`.
- Periods at defaults:
  - BCLK = 4 clocks.
  - LRCLK = 256 clocks, 50 % duty.
  - Frame = 256 clocks.
  - `frame_start_o` recurs every 256 clocks.
- First L after reset occurs in cycle 255 after release.
- Latency: a sample accepted before L appears as the MSB at `b` = 1 of the next left slot, i.e. `MCLK_DIV` + 1 clocks after L plus register delay.
- Throughput: at most one accepted sample per frame.
- `ready_o` drops the cycle after a transfer and rises the cycle after L.
- With the buffer empty, repeating the last sample is the required behaviour. Zeros are output only when no sample has been received since reset.

## Test plan
- **Reset values:** hold `rst_ni` = 0 for 10 clocks, release → during reset all outputs 0 and `ready_o` = 1. After release, `bclk_o` toggles with a 4-clock period, `lrclk_o` is 0 for 128 clocks then 1 for 128, and the first `frame_start_o` and `underrun_o` pulses occur together.
- **Single sample:** `sample_i` = 24'hA5F00F, `valid_i` for 1 clock → `ready_o` = 0 until after L. On rising BCLK edges, the left-slot bits 1..24 read A5F00F MSB first, bits 0 and 25..31 are 0, and the right slot is identical. No underrun on that L.
- **Backpressure:** present 24'h000001 then 24'h800000 with `valid_i` held high → the second sample stalls (`ready_o` = 0) until the cycle after the first L. Consecutive frames carry 000001 then 800000.
- **Underrun:** one sample 24'h123456, then `valid_i` = 0 for 3 frames → 123456 repeats in each frame, and `underrun_o` pulses once per frame coincident with `frame_start_o`.
- **Load-cycle collision:** buffer empty, `valid_i` with 24'h7FFFFF asserted exactly in L → `underrun_o` = 1 and the old frame repeats. 7FFFFF is output in the following frame and `ready_o` = 0 in between.
- **Mid-frame reset:** assert `rst_ni` = 0 at `bit_cnt` = 40 → all outputs 0 within the same cycle (asynchronous) and the pending sample is discarded. After release, timing restarts from `bit_cnt` = 0 with zeros on `sdata_o`.
